uram_event_write_sm: RTL and testbench
======================================

# uram_event_write_sm

Write-side controller for the URAM event buffer. On an accepted trigger it does four things: writes a 4-word header into the header store, streams 1536 samples per channel into three cascaded 512-deep RAMs per channel (all 8 channels in parallel), commits the event slot and publishes it to the readout side through `data_available_o`. It manages `NUM_BUFFERS` event slots as a ring and retires slots on the readout side's `complete_i` flag.

## Interface
- `NUM_BUFFERS`, 4: number of event slots; power of 2, range 2..8.
- `SLOT_BITS`, 2: equals log2(`NUM_BUFFERS`).

Ports:
- `clk_i` in 1: sole clock.
- `rstb_i` in 1: reset, asynchronous, active-low.
- `trig_i` in 1: single-cycle trigger flag.
- `trig_time_i` in 32: trigger timestamp, sampled with `trig_i`.
- `sample_valid_i` in 1: one sample per channel is present this cycle.
- `complete_i` in 1: single-cycle flag from readout; the oldest slot has been fully read.
- `wr_addr_o` out 9: RAM write address within the active RAM.
- `wr_en_o` out 3: one-hot RAM write enable (cascade position 0..2); shared by all channels.
- `wr_slot_o` out SLOT_BITS: slot being written.
- `rd_slot_o` out SLOT_BITS: oldest committed slot, for readout.
- `header_wr_o` out 1: header word write strobe.
- `header_dat_o` out 16: header word.
- `data_available_o` out 1: at least one committed, unread slot.
- `full_o` out 1: all slots committed and unread.
- `trig_dropped_o` out 1: one-cycle flag; a trigger was rejected.
- `event_count_o` out 32: events accepted since reset.

## Operation
- **States:** IDLE, HDR0, HDR1, HDR2, HDR3, WRITE, COMMIT.
- **IDLE:**
  - `trig_i` with `full_o`=0: latch `trig_time_i`, go to HDR0, increment `event_count_o`.
  - `trig_i` with `full_o`=1: pulse `trig_dropped_o` and stay in IDLE.
- **Triggers outside IDLE:** any `trig_i` in another state pulses `trig_dropped_o` and is otherwise ignored.
- **HDR0..HDR3:** one cycle each. Each asserts `header_wr_o`=1 with these `header_dat_o` values:
  - HDR0: event number [31:16].
  - HDR1: event number [15:0].
  - HDR2: time [31:16].
  - HDR3: time [15:0].
  - The event number is the post-increment `event_count_o`; the first event is 1.
  - HDR3 goes to WRITE.
- **WRITE:**
  - `wr_en_o` = `active_ram` & {3{`sample_valid_i`}}. `active_ram` resets to 3'b001 on entry to WRITE.
  - Each valid sample increments `wr_addr_o`.
  - At `wr_addr_o`=511 with a valid sample: address wraps to 0 and `active_ram` rotates left. If `active_ram` was 3'b100, go to COMMIT instead.
  - Exactly 1536 write strobes per event.
- **COMMIT:** one cycle. Increments `wr_slot_o` modulo `NUM_BUFFERS` and the occupancy count, then goes to IDLE.
- **Occupancy count:** width SLOT_BITS+1.
  - `data_available_o` = count≠0.
  - `full_o` = count==`NUM_BUFFERS`.
- **`complete_i` with count≠0:** increments `rd_slot_o` modulo `NUM_BUFFERS` and decrements the count.
- **`complete_i` with count==0:** ignored.
- **COMMIT and `complete_i` in the same cycle:** both pointers advance and the count is unchanged.
- **Arithmetic:** `event_count_o` wraps at 2^32.
- **Reset:**
  - Asynchronous reset forces IDLE with all outputs 0, including count, pointers and `event_count_o`.
  - An in-progress event is abandoned and never committed.

## Timing
- **Trigger acceptance:** `trig_i` accepted at cycle N → `header_wr_o` high during cycles N+1..N+4 → WRITE from N+5.
- **Write path:** registered; `wr_en_o`/`wr_addr_o` reflect `sample_valid_i` combinationally in WRITE, and the address updates on the following edge.
- **Commit:** the last write (`active_ram`=3'b100, addr 511) at cycle M → COMMIT at M+1 → `data_available_o`, `full_o` and `wr_slot_o` update at M+2 → IDLE at M+2.
- **Back-to-back triggers:** the earliest next trigger is accepted at M+2.
- **Complete:** `complete_i` at cycle K → `rd_slot_o`/count update at K+1.
- **`trig_dropped_o`:** registered; high for the single cycle after the rejected `trig_i`.
- **Reset values:** all outputs 0 and state IDLE.

## Test plan
- **Single event:**
  - Stimulus: reset, `trig_i` with time 0x12345678, `sample_valid_i` held high.
  - Header words: 0x0000, 0x0001, 0x1234, 0x5678.
  - 1536 strobes: 512 each on `wr_en_o` 001, 010, 100, addresses 0..511 each.
  - `data_available_o`=1 two cycles after the last strobe; `wr_slot_o`=1.
- **Gapped samples:**
  - Stimulus: `sample_valid_i` toggling 1/0.
  - Addresses advance only on valid cycles, strobe count is still 1536, and COMMIT timing follows the last valid cycle.
- **Fill and drop:**
  - Stimulus: 4 events with no `complete_i`.
  - `full_o`=1 and `wr_slot_o`=0.
  - A fifth `trig_i` → `trig_dropped_o` pulse, no header writes, `event_count_o` stays 4.
- **Simultaneous COMMIT and `complete_i`:**
  - Stimulus: count=2, `complete_i` asserted in the COMMIT cycle.
  - Count stays 2 and both `wr_slot_o` and `rd_slot_o` advance by 1.
  - Separately, `complete_i` at count 0 → no change.
- **Trigger while busy:**
  - Stimulus: `trig_i` during HDR2 and during WRITE.
  - `trig_dropped_o` pulses each time and the current event completes unaffected.
- **Reset mid-WRITE:**
  - Stimulus: assert `rstb_i`=0 at address 300 of RAM 1.
  - All outputs 0 immediately, count 0, and the next trigger writes slot 0 with event number 1.

Source files
------------

// File: rtl/uram_event_write_sm.sv
// Write-side controller for the URAM event buffer: header store, 3x512 cascaded sample
// RAMs per channel, and a ring of NUM_BUFFERS event slots handed to the readout side.
module uram_event_write_sm #(
    parameter int NUM_BUFFERS = 4,
    parameter int SLOT_BITS   = 2
) (
    input  logic                 clk_i,
    input  logic                 rstb_i,
    input  logic                 trig_i,
    input  logic [31:0]          trig_time_i,
    input  logic                 sample_valid_i,
    input  logic                 complete_i,
    output logic [8:0]           wr_addr_o,
    output logic [2:0]           wr_en_o,
    output logic [SLOT_BITS-1:0] wr_slot_o,
    output logic [SLOT_BITS-1:0] rd_slot_o,
    output logic                 header_wr_o,
    output logic [15:0]          header_dat_o,
    output logic                 data_available_o,
    output logic                 full_o,
    output logic                 trig_dropped_o,
    output logic [31:0]          event_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR0   = 3'd1,
        ST_HDR1   = 3'd2,
        ST_HDR2   = 3'd3,
        ST_HDR3   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_COMMIT = 3'd6
    } state_t;

    localparam logic [SLOT_BITS:0]   OCC_ONE  = (SLOT_BITS+1)'(1);
    localparam logic [SLOT_BITS:0]   OCC_FULL = (SLOT_BITS+1)'(NUM_BUFFERS);
    localparam logic [SLOT_BITS-1:0] SLOT_ONE = SLOT_BITS'(1);

    state_t               state_r, state_next_s;
    logic [8:0]           addr_r, addr_next_s;
    logic [2:0]           active_ram_r, active_ram_next_s;
    logic [31:0]          time_r, time_next_s;
    logic [31:0]          event_count_r, event_count_next_s;
    logic [SLOT_BITS-1:0] wr_slot_r, wr_slot_next_s;
    logic [SLOT_BITS-1:0] rd_slot_r, rd_slot_next_s;
    logic [SLOT_BITS:0]   occ_r, occ_next_s;
    logic                 avail_r, full_r, dropped_r, hdr_wr_r;
    logic [15:0]          hdr_dat_r, hdr_dat_s;
    logic                 hdr_wr_s, drop_s, commit_s, retire_s;

    // Next-state, write datapath and slot ring bookkeeping.
    always_comb begin
        state_next_s       = state_r;
        addr_next_s        = addr_r;
        active_ram_next_s  = active_ram_r;
        time_next_s        = time_r;
        event_count_next_s = event_count_r;
        drop_s             = 1'b0;
        commit_s           = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (trig_i) begin
                    if (!full_r) begin
                        time_next_s        = trig_time_i;
                        event_count_next_s = event_count_r + 32'd1;
                        state_next_s       = ST_HDR0;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end
            ST_HDR0: state_next_s = ST_HDR1;
            ST_HDR1: state_next_s = ST_HDR2;
            ST_HDR2: state_next_s = ST_HDR3;
            ST_HDR3: begin
                state_next_s      = ST_WRITE;
                addr_next_s       = 9'd0;
                active_ram_next_s = 3'b001;
            end
            ST_WRITE: begin
                if (sample_valid_i) begin
                    if (addr_r == 9'd511) begin
                        addr_next_s = 9'd0;
                        if (active_ram_r == 3'b100) begin
                            state_next_s = ST_COMMIT;
                        end else begin
                            active_ram_next_s = {active_ram_r[1:0], active_ram_r[2]};
                        end
                    end else begin
                        addr_next_s = addr_r + 9'd1;
                    end
                end else begin
                    addr_next_s = addr_r;
                end
            end
            ST_COMMIT: begin
                commit_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase

        // A trigger anywhere but IDLE is never accepted.
        if (trig_i && (state_r != ST_IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = drop_s;
        end

        retire_s       = complete_i && (occ_r != '0);
        wr_slot_next_s = commit_s ? (wr_slot_r + SLOT_ONE) : wr_slot_r;
        rd_slot_next_s = retire_s ? (rd_slot_r + SLOT_ONE) : rd_slot_r;
        case ({commit_s, retire_s})
            2'b10:   occ_next_s = occ_r + OCC_ONE;
            2'b01:   occ_next_s = occ_r - OCC_ONE;
            default: occ_next_s = occ_r;
        endcase

        // Header word for the cycle being entered, so the strobe leaves a flop.
        hdr_wr_s  = 1'b1;
        case (state_next_s)
            ST_HDR0: hdr_dat_s = event_count_next_s[31:16];
            ST_HDR1: hdr_dat_s = event_count_next_s[15:0];
            ST_HDR2: hdr_dat_s = time_next_s[31:16];
            ST_HDR3: hdr_dat_s = time_next_s[15:0];
            default: begin
                hdr_wr_s  = 1'b0;
                hdr_dat_s = 16'h0000;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_r       <= ST_IDLE;
            addr_r        <= 9'd0;
            active_ram_r  <= 3'b001;
            time_r        <= 32'd0;
            event_count_r <= 32'd0;
            wr_slot_r     <= '0;
            rd_slot_r     <= '0;
            occ_r         <= '0;
            avail_r       <= 1'b0;
            full_r        <= 1'b0;
            dropped_r     <= 1'b0;
            hdr_wr_r      <= 1'b0;
            hdr_dat_r     <= 16'h0000;
        end else begin
            state_r       <= state_next_s;
            addr_r        <= addr_next_s;
            active_ram_r  <= active_ram_next_s;
            time_r        <= time_next_s;
            event_count_r <= event_count_next_s;
            wr_slot_r     <= wr_slot_next_s;
            rd_slot_r     <= rd_slot_next_s;
            occ_r         <= occ_next_s;
            avail_r       <= (occ_next_s != '0);
            full_r        <= (occ_next_s == OCC_FULL);
            dropped_r     <= drop_s;
            hdr_wr_r      <= hdr_wr_s;
            hdr_dat_r     <= hdr_dat_s;
        end
    end

    // Enables follow sample_valid_i in the same cycle so the RAM write lands on the next edge.
    assign wr_en_o          = (state_r == ST_WRITE) ? (active_ram_r & {3{sample_valid_i}}) : 3'b000;
    assign wr_addr_o        = addr_r;
    assign wr_slot_o        = wr_slot_r;
    assign rd_slot_o        = rd_slot_r;
    assign header_wr_o      = hdr_wr_r;
    assign header_dat_o     = hdr_dat_r;
    assign data_available_o = avail_r;
    assign full_o           = full_r;
    assign trig_dropped_o   = dropped_r;
    assign event_count_o    = event_count_r;

endmodule

// File: tb/tb_uram_event_write_sm.sv
// Directed bench for uram_event_write_sm: header words, strobe/address sequence,
// slot ring occupancy, trigger drops and asynchronous reset mid-event.
module tb_uram_event_write_sm;

    logic        clk_i = 1'b0;
    logic        rstb_i, trig_i, sample_valid_i, complete_i;
    logic [31:0] trig_time_i;
    logic [8:0]  wr_addr_o;
    logic [2:0]  wr_en_o;
    logic [1:0]  wr_slot_o, rd_slot_o;
    logic        header_wr_o, data_available_o, full_o, trig_dropped_o;
    logic [15:0] header_dat_o;
    logic [31:0] event_count_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_evt;
    logic [1:0]  exp_wr, exp_rd;
    int          exp_occ;

    always #5 clk_i = ~clk_i;

    uram_event_write_sm #(.NUM_BUFFERS(4), .SLOT_BITS(2)) dut (
        .clk_i(clk_i), .rstb_i(rstb_i), .trig_i(trig_i), .trig_time_i(trig_time_i),
        .sample_valid_i(sample_valid_i), .complete_i(complete_i),
        .wr_addr_o(wr_addr_o), .wr_en_o(wr_en_o), .wr_slot_o(wr_slot_o),
        .rd_slot_o(rd_slot_o), .header_wr_o(header_wr_o), .header_dat_o(header_dat_o),
        .data_available_o(data_available_o), .full_o(full_o),
        .trig_dropped_o(trig_dropped_o), .event_count_o(event_count_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_addr"},  32'(wr_addr_o), 32'd0);
        check_eq({tag, "_en"},    32'(wr_en_o), 32'd0);
        check_eq({tag, "_wslot"}, 32'(wr_slot_o), 32'd0);
        check_eq({tag, "_rslot"}, 32'(rd_slot_o), 32'd0);
        check_eq({tag, "_hwr"},   32'(header_wr_o), 32'd0);
        check_eq({tag, "_hdat"},  32'(header_dat_o), 32'd0);
        check_eq({tag, "_avail"}, 32'(data_available_o), 32'd0);
        check_eq({tag, "_full"},  32'(full_o), 32'd0);
        check_eq({tag, "_drop"},  32'(trig_dropped_o), 32'd0);
        check_eq({tag, "_evt"},   event_count_o, 32'd0);
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_wslot"}, 32'(wr_slot_o), 32'(exp_wr));
        check_eq({tag, "_rslot"}, 32'(rd_slot_o), 32'(exp_rd));
        check_eq({tag, "_avail"}, 32'(data_available_o), 32'(exp_occ != 0));
        check_eq({tag, "_full"},  32'(full_o), 32'(exp_occ == 4));
        check_eq({tag, "_evt"},   event_count_o, exp_evt);
    endtask

    task automatic do_complete(input string tag);
        complete_i = 1'b1;
        step();
        complete_i = 1'b0;
        if (exp_occ != 0) begin
            exp_rd++;
            exp_occ--;
        end
        check_model(tag);
    endtask

    // One full event from IDLE; abort_at > 0 pulls reset at that strobe index instead.
    task automatic run_event(input logic [31:0] t, input bit gapped, input bit busy,
                             input bit cmpl, input int abort_at);
        int          strobes = 0;
        int          bad = 0;
        bit          sv;
        bit          drop_done = 1'b0;
        logic [2:0]  exp_en;
        logic [15:0] hdr [4];
        exp_evt = exp_evt + 32'd1;
        hdr[0] = exp_evt[31:16];
        hdr[1] = exp_evt[15:0];
        hdr[2] = t[31:16];
        hdr[3] = t[15:0];
        trig_i = 1'b1;
        trig_time_i = t;
        step();
        trig_i = 1'b0;
        trig_time_i = 32'd0;
        check_eq("evt_count", event_count_o, exp_evt);
        for (int h = 0; h < 4; h++) begin
            if (busy && h == 2) trig_i = 1'b1;
            check_eq($sformatf("hdr%0d_wr", h), 32'(header_wr_o), 32'd1);
            check_eq($sformatf("hdr%0d_dat", h), 32'(header_dat_o), 32'(hdr[h]));
            step();
            if (trig_i) begin
                trig_i = 1'b0;
                check_eq("drop_in_hdr2", 32'(trig_dropped_o), 32'd1);
            end
        end
        for (int cyc = 0; cyc < 4000 && strobes < 1536; cyc++) begin
            sv = gapped ? (cyc % 2 == 0) : 1'b1;
            sample_valid_i = sv;
            if (abort_at > 0 && strobes == abort_at) begin
                check_eq("pre_rst_addr", 32'(wr_addr_o), 32'd300);
                check_eq("pre_rst_en", 32'(wr_en_o), 32'd2);
                rstb_i = 1'b0;
                #1;
                check_zero("rst_mid");
                check_eq("rst_seq_errs", 32'(bad), 32'd0);
                sample_valid_i = 1'b0;
                step();
                rstb_i = 1'b1;
                exp_evt = 32'd0;
                exp_wr  = 2'd0;
                exp_rd  = 2'd0;
                exp_occ = 0;
                return;
            end
            if (busy && !drop_done && strobes == 700 && sv) begin
                trig_i = 1'b1;
                drop_done = 1'b1;
            end
            #1;
            exp_en = sv ? (3'b001 << (strobes / 512)) : 3'b000;
            if (wr_en_o !== exp_en) bad++;
            if (sv && wr_addr_o !== 9'(strobes % 512)) bad++;
            if (sv) strobes++;
            step();
            if (trig_i) begin
                trig_i = 1'b0;
                check_eq("drop_in_write", 32'(trig_dropped_o), 32'd1);
            end
        end
        sample_valid_i = 1'b0;
        check_eq("strobe_count", 32'(strobes), 32'd1536);
        check_eq("addr_seq_errs", 32'(bad), 32'd0);
        check_eq("commit_avail", 32'(data_available_o), 32'(exp_occ != 0));
        check_eq("commit_hwr", 32'(header_wr_o), 32'd0);
        complete_i = cmpl;
        step();
        complete_i = 1'b0;
        exp_wr++;
        if (cmpl && exp_occ != 0) begin
            exp_rd++;
            exp_occ--;
        end
        exp_occ++;
        check_model("post_commit");
    endtask

    initial begin
        rstb_i = 1'b0;
        trig_i = 1'b0;
        trig_time_i = 32'd0;
        sample_valid_i = 1'b0;
        complete_i = 1'b0;
        exp_evt = 32'd0;
        exp_wr = 2'd0;
        exp_rd = 2'd0;
        exp_occ = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        rstb_i = 1'b1;
        step();

        // Single event, then retire it and retire again at empty.
        run_event(32'h12345678, 1'b0, 1'b0, 1'b0, 0);
        do_complete("complete_one");
        do_complete("complete_empty");

        // Gapped samples with triggers during HDR2 and WRITE.
        run_event(32'hCAFE0001, 1'b1, 1'b1, 1'b0, 0);
        run_event(32'h0000FFFF, 1'b0, 1'b0, 1'b0, 0);
        // Count is 2 here; retire in the COMMIT cycle.
        run_event(32'hA5A55A5A, 1'b0, 1'b0, 1'b1, 0);

        // Reset at address 300 of the second RAM.
        run_event(32'h11112222, 1'b0, 1'b0, 1'b0, 812);
        check_model("after_reset");

        // Refill all four slots from a clean ring.
        run_event(32'h00010002, 1'b0, 1'b0, 1'b0, 0);
        run_event(32'hFFFF0000, 1'b1, 1'b0, 1'b0, 0);
        run_event(32'h87654321, 1'b0, 1'b0, 1'b0, 0);
        run_event(32'h0BADBEEF, 1'b0, 1'b0, 1'b0, 0);
        check_eq("fill_full", 32'(full_o), 32'd1);
        check_eq("fill_wslot", 32'(wr_slot_o), 32'd0);

        // Trigger while full.
        trig_i = 1'b1;
        trig_time_i = 32'hDEADDEAD;
        step();
        trig_i = 1'b0;
        check_eq("full_drop", 32'(trig_dropped_o), 32'd1);
        check_eq("full_no_hdr", 32'(header_wr_o), 32'd0);
        check_eq("full_evt", event_count_o, 32'd4);
        step();
        check_eq("full_drop_clear", 32'(trig_dropped_o), 32'd0);
        check_eq("full_no_hdr2", 32'(header_wr_o), 32'd0);
        check_model("full_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
